// File: rtl/approx_mult_pkg.sv
// Shared types for the sequential approximate multiplier.
//   mode_e  : per-partial-product approximation mode (2 bits)
//   state_e : controller states IDLE / BUSY / DONE
package approx_mult_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT   = 2'd0,
    MODE_TRUNC   = 2'd1,
    MODE_OPTRUNC = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/approx_mult_seq_mul4x4.sv
// approx_mul4x4: combinational 4x4 unsigned multiplier core with selectable
// approximation. Every mode yields a product no larger than the exact one.
//   a4, b4 : 4-bit operands
//   mode   : MODE_EXACT / MODE_TRUNC / MODE_OPTRUNC / MODE_RSVD (= exact)
//   p      : 8-bit product
module approx_mul4x4
  import approx_mult_pkg::*;
(
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  mode_e      mode,
  output logic [7:0] p
);

  logic [7:0] exact;

  assign exact = {4'b0000, a4} * {4'b0000, b4};

  always_comb begin
    p = exact;
    case (mode)
      MODE_TRUNC:   p = exact & 8'hFC;
      // Dropping the multiplier LSB removes one copy of a4 at most.
      MODE_OPTRUNC: p = {4'b0000, a4} * {4'b0000, b4 & 4'hE};
      default:      p = exact;
    endcase
  end

endmodule

// File: rtl/approx_mult_seq.sv
// approx_mult_seq: iterative WIDTH x WIDTH approximate unsigned multiplier.
// One 4x4 nibble partial product per cycle through a single shared core;
// partial products with i+j < APPROX_LEVEL use the latched mode.
// Optional feature macro: APPROX_MULT_ERR_STAT_EN adds the err / err_cnt ports.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   a, b, mode            : operands and approximation mode
//   out_valid / out_ready : result handshake
//   r                     : 2*WIDTH product
//   err, err_cnt          : exact-minus-approx and saturating nonzero-err count
module approx_mult_seq
  import approx_mult_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int APPROX_LEVEL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] r
`ifdef APPROX_MULT_ERR_STAT_EN
  ,
  output logic [2*WIDTH-1:0] err,
  output logic [15:0]        err_cnt
`endif
);

  localparam int N  = WIDTH / 4;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = 2 * WIDTH;

  state_e          state_q, state_d;
  logic [NW-1:0]   i_q, i_d, j_q, j_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  mode_e           mode_q, mode_d;
  logic [AW-1:0]   acc_q, acc_d, r_q, r_d;
  logic            out_valid_q, out_valid_d;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [3:0]      a_nib, b_nib;
  int              ij_sum;
  mode_e           pp_mode;
  logic [7:0]      pp;
  logic            last;

  // i walks nibbles of a, j walks nibbles of b; (i,j) is idx split in two.
  assign a_sh    = a_q >> {i_q, 2'b00};
  assign b_sh    = b_q >> {j_q, 2'b00};
  assign a_nib   = a_sh[3:0];
  assign b_nib   = b_sh[3:0];
  assign ij_sum  = int'(i_q) + int'(j_q);
  assign pp_mode = (ij_sum < APPROX_LEVEL) ? mode_q : MODE_EXACT;
  assign last    = (i_q == NW'(N - 1)) && (j_q == NW'(N - 1));

  approx_mul4x4 u_mul4 (
    .a4   (a_nib),
    .b4   (b_nib),
    .mode (pp_mode),
    .p    (pp)
  );

`ifdef APPROX_MULT_ERR_STAT_EN
  logic [AW-1:0] exact_q, exact_d, err_q, err_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [7:0]    pp_exact;

  assign pp_exact = {4'b0000, a_nib} * {4'b0000, b_nib};
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign r         = r_q;

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    r_d         = r_q;
    out_valid_d = out_valid_q;
`ifdef APPROX_MULT_ERR_STAT_EN
    exact_d     = exact_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode_e'(mode);
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
`ifdef APPROX_MULT_ERR_STAT_EN
          exact_d = '0;
`endif
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d = acc_q + (AW'(pp) << (4 * ij_sum));
`ifdef APPROX_MULT_ERR_STAT_EN
        exact_d = exact_q + (AW'(pp_exact) << (4 * ij_sum));
`endif
        if (last) begin
          r_d         = acc_d;
          out_valid_d = 1'b1;
`ifdef APPROX_MULT_ERR_STAT_EN
          err_d       = exact_d - acc_d;
`endif
          state_d     = ST_DONE;
        end else if (j_q == NW'(N - 1)) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef APPROX_MULT_ERR_STAT_EN
          if ((err_q != '0) && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
`endif
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= MODE_EXACT;
      acc_q       <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
`ifdef APPROX_MULT_ERR_STAT_EN
      exact_q     <= '0;
      err_q       <= '0;
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
`ifdef APPROX_MULT_ERR_STAT_EN
      exact_q     <= exact_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_approx_mult_seq.sv
module tb_approx_mult_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Three WIDTH=8 instances share inputs: APPROX_LEVEL 1, 3 and 0.
  logic        in_valid, out_ready;
  logic [7:0]  a, b;
  logic [1:0]  mode;
  logic        in_ready, out_valid, l3_in_ready, l3_out_valid, l0_in_ready, l0_out_valid;
  logic [15:0] r, l3_r, l0_r;

  // WIDTH=16 exact instance.
  logic        iv16, or16, ir16, ov16;
  logic [15:0] a16, b16;
  logic [31:0] r16;

`ifdef APPROX_MULT_ERR_STAT_EN
  logic [15:0] err, l3_err, l0_err;
  logic [15:0] err_cnt, l3_err_cnt, l0_err_cnt, cnt16;
  logic [31:0] err16;
`endif

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  approx_mult_seq #(.WIDTH(8), .APPROX_LEVEL(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .r(r)
`ifdef APPROX_MULT_ERR_STAT_EN
    , .err(err), .err_cnt(err_cnt)
`endif
  );

  approx_mult_seq #(.WIDTH(8), .APPROX_LEVEL(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l3_in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(l3_out_valid), .out_ready(out_ready), .r(l3_r)
`ifdef APPROX_MULT_ERR_STAT_EN
    , .err(l3_err), .err_cnt(l3_err_cnt)
`endif
  );

  approx_mult_seq #(.WIDTH(8), .APPROX_LEVEL(0)) u_l0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l0_in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(l0_out_valid), .out_ready(out_ready), .r(l0_r)
`ifdef APPROX_MULT_ERR_STAT_EN
    , .err(l0_err), .err_cnt(l0_err_cnt)
`endif
  );

  approx_mult_seq #(.WIDTH(16), .APPROX_LEVEL(0)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .mode(2'd1), .out_valid(ov16), .out_ready(or16), .r(r16)
`ifdef APPROX_MULT_ERR_STAT_EN
    , .err(err16), .err_cnt(cnt16)
`endif
  );

  // Called at #1 after an edge with the W8 instances in IDLE.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] tm,
                      output int lat);
    in_valid = 1'b1; a = ta; b = tb; mode = tm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; mode = '0;
    iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || r !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b r=%h, want 1 0 0000", in_ready, out_valid, r);
    end
`ifdef APPROX_MULT_ERR_STAT_EN
    checks++;
    if (err !== 16'h0 || err_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_err: err=%h err_cnt=%0d, want 0 0", err, err_cnt);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_modes();
    logic [1:0]  tm [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [15:0] tr [4] = '{16'h138D, 16'h138C, 16'h1386, 16'h138D};
    logic [15:0] te [4] = '{16'h0000, 16'h0001, 16'h0007, 16'h0000};
    int lat;
    for (int k = 0; k < 4; k++) begin
      run8(8'h37, 8'h5B, tm[k], lat);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL mode%0d_latency: got %0d, want 4", k, lat);
      end
      checks++;
      if (r !== tr[k]) begin
        errors++;
        $display("FAIL mode%0d_r: got %h, want %h", k, r, tr[k]);
      end
`ifdef APPROX_MULT_ERR_STAT_EN
      checks++;
      if (err !== te[k]) begin
        errors++;
        $display("FAIL mode%0d_err: got %h, want %h", k, err, te[k]);
      end
      if (te[k] != 16'h0) exp_cnt++;
`endif
      handshake();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL mode%0d_release: out_valid=%b in_ready=%b, want 0 1", k, out_valid, in_ready);
      end
`ifdef APPROX_MULT_ERR_STAT_EN
      checks++;
      if (err_cnt !== 16'(exp_cnt)) begin
        errors++;
        $display("FAIL mode%0d_err_cnt: got %0d, want %0d", k, err_cnt, exp_cnt);
      end
`endif
    end
  endtask

  task automatic test_approx_level();
    int lat;
    run8(8'hFF, 8'hFF, 2'd1, lat);
    checks++;
    if (r !== 16'hFE00) begin
      errors++;
      $display("FAIL level1_r: got %h, want FE00", r);
    end
    checks++;
    if (l3_out_valid !== 1'b1 || l3_r !== 16'hFCE0) begin
      errors++;
      $display("FAIL level3_r: valid=%b r=%h, want 1 FCE0", l3_out_valid, l3_r);
    end
    checks++;
    if (l0_out_valid !== 1'b1 || l0_r !== 16'hFE01) begin
      errors++;
      $display("FAIL level0_r: valid=%b r=%h, want 1 FE01", l0_out_valid, l0_r);
    end
`ifdef APPROX_MULT_ERR_STAT_EN
    checks++;
    if (err !== 16'h0001 || l3_err !== 16'h0121 || l0_err !== 16'h0000) begin
      errors++;
      $display("FAIL level_err: got %h %h %h, want 0001 0121 0000", err, l3_err, l0_err);
    end
    exp_cnt++;
`endif
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    run8(8'h12, 8'h34, 2'd0, lat);
    in_valid = 1'b1; a = 8'h0F; b = 8'h0F; mode = 2'd0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || r !== 16'h03A8 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b r=%h in_ready=%b, want 1 03A8 0", c, out_valid, r, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: in_ready=%b, want 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4 || r !== 16'h00E1) begin
      errors++;
      $display("FAIL bp_next: lat=%0d r=%h, want 4 00E1", lat, r);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    in_valid = 1'b1; a = 8'h37; b = 8'h5B; mode = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || r !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid: out_valid=%b in_ready=%b r=%h, want 0 1 0000", out_valid, in_ready, r);
    end
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_no_result: out_valid seen %0d cycles, want 0", seen);
    end
    exp_cnt = 0;
    run8(8'hFF, 8'h01, 2'd0, lat);
    checks++;
    if (lat !== 4 || r !== 16'h00FF) begin
      errors++;
      $display("FAIL rst_next: lat=%0d r=%h, want 4 00FF", lat, r);
    end
    handshake();
`ifdef APPROX_MULT_ERR_STAT_EN
    checks++;
    if (err_cnt !== 16'h0) begin
      errors++;
      $display("FAIL rst_err_cnt: got %0d, want 0", err_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [15:0] ea, eb;
    logic [31:0] exp32;
    int since;
    int g;
    since = 0;
    or16 = 1'b1; iv16 = 1'b1;
    a16 = 16'($urandom); b16 = 16'($urandom);
    for (int n = 0; n < 1000; n++) begin
      g = 0;
      while (!ir16 && g < 100) begin
        @(posedge clk); #1;
        g++; since++;
      end
      ea = a16; eb = b16;
      @(posedge clk);
      since++;
      if (n > 0) begin
        checks++;
        if (since !== 18) begin
          errors++;
          $display("FAIL b2b_interval%0d: got %0d, want 18", n, since);
        end
      end
      since = 0;
      #1;
      a16 = 16'($urandom); b16 = 16'($urandom);
      g = 0;
      while (!ov16 && g < 100) begin
        @(posedge clk); #1;
        g++; since++;
      end
      exp32 = 32'(ea) * 32'(eb);
      checks++;
      if (ov16 !== 1'b1 || r16 !== exp32) begin
        errors++;
        $display("FAIL b2b_r%0d: %h*%h got %h valid=%b, want %h", n, ea, eb, r16, ov16, exp32);
        break;
      end
    end
    iv16 = 1'b0;
    @(posedge clk); #1;
    or16 = 1'b0;
`ifdef APPROX_MULT_ERR_STAT_EN
    checks++;
    if (cnt16 !== 16'h0) begin
      errors++;
      $display("FAIL b2b_err_cnt: got %0d, want 0", cnt16);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_modes();
    test_approx_level();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/approx_mult_seq.md
# approx_mult_seq

Iterative, parametrised approximate unsigned multiplier that computes a WIDTH×WIDTH product from 4×4 nibble partial products, one per cycle, with run-time selectable approximation. It is the sequential, width-generic successor to the fixed 8×8 four-quadrant approximate multipliers in the multiplier library. It targets area-constrained datapaths in which a single 4×4 core is reused across all partial products.

## Interface
- WIDTH, 8, operand width in bits; multiple of 4, ≥4; N = WIDTH/4 nibbles per operand
- APPROX_LEVEL, 1, partial product (i,j) uses the approximate mode when i+j < APPROX_LEVEL; 0 = all exact; ≥2N−1 = all approximate

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands/mode valid
- in_ready  out  1  block can accept; high only in IDLE
- a  in  WIDTH  multiplicand, unsigned
- b  in  WIDTH  multiplier, unsigned
- mode  in  2  approximation mode, sampled at acceptance
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- r  out  2*WIDTH  product
- err  out  2*WIDTH  exact − approximate product (ERR_STAT only)
- err_cnt  out  16  saturating count of results with err≠0 (ERR_STAT only)

## Operation
- FSM states: IDLE, BUSY, DONE. Reset → IDLE, acc=0, idx=0, r=0, out_valid=0, in_ready=1, err=0, err_cnt=0.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, mode; clear acc; set idx=0; go to BUSY.
- BUSY: i = idx / N (nibble of a), j = idx % N (nibble of b). Compute pp = mul4(a[4i+:4], b[4j+:4], m), where m = latched mode if i+j < APPROX_LEVEL, otherwise EXACT. Set acc += pp << 4(i+j). After the add for idx = N²−1, go to DONE. Otherwise increment idx.
- DONE: r = acc and out_valid=1. Both hold stable until out_valid&&out_ready, then go to IDLE. in_ready=0 in DONE, so no overlap of input and output.
- mul4 modes (a4, b4 are 4-bit):
  - 0 EXACT: a4*b4
  - 1 TRUNC: (a4*b4) & 8'hFC
  - 2 OPTRUNC: a4*(b4 & 4'hE)
  - 3 reserved: behaves as EXACT
- Width rules: acc is 2*WIDTH bits. Every mode satisfies approx ≤ exact, so acc never overflows and err ≥ 0.
- Inputs are ignored outside IDLE. Changing a, b or mode during BUSY has no effect.
- rst_n low in any state aborts the operation immediately and applies the reset values. No partial result is emitted.

## Timing
- Acceptance at edge k puts out_valid high after edge k+N² (WIDTH=8 → 4 cycles; WIDTH=16 → 16).
- Minimum issue interval with in_valid and out_ready held high is N²+2 cycles: one cycle in DONE for the handshake, one in IDLE for acceptance.
- in_ready is combinational from state only. out_valid and r are registered.

## Configuration
- APPROX_MULT_ERR_STAT_EN defined:
  - A second accumulator sums the exact pp for every idx.
  - In DONE, err = exact − acc, valid with out_valid.
  - err_cnt increments by 1 at each output handshake where err≠0 and saturates at 16'hFFFF.
- Undefined: the exact accumulator, err and err_cnt are absent. The ports are not declared.

## Structure
- Package approx_mult_pkg: mode typedef (MODE_EXACT, MODE_TRUNC, MODE_OPTRUNC, MODE_RSVD) and FSM state typedef.
- Sub-module approx_mul4x4 (a4, b4, mode → 8-bit p): purely combinational, instantiated once and reused across all partial products.

## Test plan
- WIDTH=8, APPROX_LEVEL=1, mode=EXACT, a=0x37, b=0x5B → r=0x138D, out_valid 4 cycles after acceptance; err=0 when ERR_STAT is on.
- Same operands, mode=TRUNC → r=0x138C, err=1. Same operands, mode=OPTRUNC → r=0x1386, err=7; err_cnt increments once per result.
- WIDTH=8, APPROX_LEVEL=3, mode=TRUNC, a=b=0xFF → r=0xFCE0, err=0x0121. APPROX_LEVEL=0 with the same operands → r=0xFE01.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → r and out_valid stay stable, in_ready=0, and a new in_valid is not accepted. Release → IDLE, then the next operand is accepted one cycle later.
- Reset mid-operation: drop rst_n during BUSY at idx=2 → out_valid=0, in_ready=1 immediately, and no result is emitted. The next operation, 0xFF×0x01 EXACT, gives r=0x00FF.
- WIDTH=16, APPROX_LEVEL=0, random 1000 operands back-to-back → r = a*b exactly, issue interval 18 cycles.
